// File: rtl/btn_event_arbiter_if.sv
// Event handshake between the button arbiter (master) and its consumer (slave).
interface btn_event_arbiter_if #(
  parameter int ID_W = 2
) ();
  logic            evt_valid;
  logic [ID_W-1:0] evt_id;
  logic            evt_ready;

  modport master (output evt_valid, output evt_id, input evt_ready);
  modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface

// File: rtl/btn_event_arbiter.sv
// Turns debounced button presses into single queued events, granted round-robin.
// Optional hold-to-repeat edges are enabled by defining BTN_AUTO_REPEAT_EN.
module btn_event_arbiter #(
  parameter int N_BTN         = 4,
  parameter int ID_W          = 2,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_BTN-1:0]    btn_db_i,
  btn_event_arbiter_if.master evt_if,
  output logic                ovf_o,
  input  logic                ovf_clr_i
);

  logic [N_BTN-1:0] dly_q;
  logic [N_BTN-1:0] pending_q, pending_d;
  logic [N_BTN-1:0] rise_w, syn_w, grant_w, drop_w;
  logic             evt_valid_q, evt_valid_d;
  logic [ID_W-1:0]  evt_id_q, evt_id_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic             ovf_q, ovf_d;
  logic             load_w, found_w;
  logic [ID_W-1:0]  winner_w;

  // The output slot frees in the same cycle it is accepted.
  assign load_w = ~evt_valid_q | evt_if.evt_ready;

  always_comb begin
    int idx;
    found_w  = 1'b0;
    winner_w = '0;
    idx      = 0;
    for (int off = 1; off <= N_BTN; off++) begin
      idx = int'(last_grant_q) + off;
      if (idx >= N_BTN) idx = idx - N_BTN;
      if (!found_w && pending_q[idx]) begin
        found_w  = 1'b1;
        winner_w = ID_W'(idx);
      end
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam int MAX_CNT = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_repeat
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             rep_q, rep_d;
      logic             fire_w;

      // rep_q selects the shorter period once the first repeat has fired.
      assign fire_w = btn_db_i[gi] &
                      (rep_q ? (cnt_q == CNT_W'(REPEAT_PERIOD)) : (cnt_q == CNT_W'(REPEAT_DELAY)));

      always_comb begin
        cnt_d = cnt_q;
        rep_d = rep_q;
        if (!btn_db_i[gi]) begin
          cnt_d = '0;
          rep_d = 1'b0;
        end else if (fire_w) begin
          cnt_d = CNT_W'(1);
          rep_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
          rep_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          rep_q <= rep_d;
        end
      end

      assign syn_w[gi] = fire_w;
    end
  endgenerate
`else
  assign syn_w = '0;
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_repeat_cfg_unused
  end
`endif

  genvar gj;
  generate
    for (gj = 0; gj < N_BTN; gj++) begin : g_btn
      assign rise_w[gj]    = (btn_db_i[gj] & ~dly_q[gj]) | syn_w[gj];
      assign grant_w[gj]   = load_w & found_w & (winner_w == ID_W'(gj));
      // A same-cycle grant frees the slot, so the new press re-queues instead of dropping.
      assign drop_w[gj]    = rise_w[gj] & pending_q[gj] & ~grant_w[gj];
      assign pending_d[gj] = rise_w[gj] | (pending_q[gj] & ~grant_w[gj]);
    end
  endgenerate

  always_comb begin
    evt_valid_d  = evt_valid_q;
    evt_id_d     = evt_id_q;
    last_grant_d = last_grant_q;
    if (load_w) begin
      evt_valid_d = found_w;
      if (found_w) begin
        evt_id_d     = winner_w;
        last_grant_d = winner_w;
      end
    end
  end

  assign ovf_d = ovf_clr_i ? 1'b0 : (ovf_q | (|drop_w));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_q        <= '0;
      pending_q    <= '0;
      evt_valid_q  <= 1'b0;
      evt_id_q     <= '0;
      last_grant_q <= ID_W'(N_BTN - 1);
      ovf_q        <= 1'b0;
    end else begin
      dly_q        <= btn_db_i;
      pending_q    <= pending_d;
      evt_valid_q  <= evt_valid_d;
      evt_id_q     <= evt_id_d;
      last_grant_q <= last_grant_d;
      ovf_q        <= ovf_d;
    end
  end

  assign evt_if.evt_valid = evt_valid_q;
  assign evt_if.evt_id    = evt_id_q;
  assign ovf_o            = ovf_q;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed self-checking bench for btn_event_arbiter; inputs driven and outputs sampled on negedge.
module tb_btn_event_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_db = '0;
  logic       ovf;
  logic       ovf_clr = 1'b0;
  int         checks = 0;
  int         errors = 0;

  btn_event_arbiter_if #(.ID_W(2)) bus ();

  btn_event_arbiter #(
    .N_BTN(4),
    .ID_W(2)
`ifdef BTN_AUTO_REPEAT_EN
    ,
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(4)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_db_i(btn_db),
    .evt_if(bus),
    .ovf_o(ovf),
    .ovf_clr_i(ovf_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    btn_db = '0;
    bus.evt_ready = 1'b0;
    ovf_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    bus.evt_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.evt_valid); end
    checks++;
    if (bus.evt_id !== 2'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", bus.evt_id); end
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_press;
    int n_evt;
    logic exp_v;
    n_evt = 0;
    do_reset();
    bus.evt_ready = 1'b1;
    btn_db[2] = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      exp_v = (c == 2);
      checks++;
      if (bus.evt_valid !== exp_v) begin errors++; $display("FAIL single_valid c=%0d got=%b exp=%b", c, bus.evt_valid, exp_v); end
      if (bus.evt_valid === 1'b1) begin
        n_evt++;
        $display("single: event id=%0d at cycle %0d", bus.evt_id, c);
        checks++;
        if (bus.evt_id !== 2'd2) begin errors++; $display("FAIL single_id got=%0d exp=2", bus.evt_id); end
      end
      if (c == 20) btn_db[2] = 1'b0;
    end
    checks++;
    if (n_evt != 1) begin errors++; $display("FAIL single_count got=%0d exp=1", n_evt); end
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL single_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_back_to_back;
    logic [1:0] ids [3];
    logic exp_v;
    ids[0] = 2'd0; ids[1] = 2'd1; ids[2] = 2'd3;
    do_reset();
    bus.evt_ready = 1'b1;
    btn_db = 4'b1011;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      exp_v = (c >= 2 && c <= 4);
      checks++;
      if (bus.evt_valid !== exp_v) begin errors++; $display("FAIL b2b_valid c=%0d got=%b exp=%b", c, bus.evt_valid, exp_v); end
      if (exp_v) begin
        $display("b2b: event id=%0d at cycle %0d", bus.evt_id, c);
        checks++;
        if (bus.evt_id !== ids[c-2]) begin errors++; $display("FAIL b2b_id c=%0d got=%0d exp=%0d", c, bus.evt_id, ids[c-2]); end
      end
      if (c == 3) btn_db = '0;
    end
  endtask

  task automatic test_rr_wrap;
    logic [1:0] ids [2];
    logic exp_v;
    ids[0] = 2'd3; ids[1] = 2'd0;
    do_reset();
    bus.evt_ready = 1'b1;
    btn_db[1] = 1'b1;
    @(negedge clk);
    btn_db[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.evt_valid !== 1'b1 || bus.evt_id !== 2'd1) begin
      errors++; $display("FAIL rr_setup got valid=%b id=%0d exp valid=1 id=1", bus.evt_valid, bus.evt_id);
    end
    @(negedge clk);
    btn_db = 4'b1001;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      exp_v = (c == 2 || c == 3);
      checks++;
      if (bus.evt_valid !== exp_v) begin errors++; $display("FAIL rr_valid c=%0d got=%b exp=%b", c, bus.evt_valid, exp_v); end
      if (exp_v) begin
        $display("rr: event id=%0d at cycle %0d", bus.evt_id, c);
        checks++;
        if (bus.evt_id !== ids[c-2]) begin errors++; $display("FAIL rr_id c=%0d got=%0d exp=%0d", c, bus.evt_id, ids[c-2]); end
      end
      if (c == 2) btn_db = '0;
    end
  endtask

  task automatic test_overflow;
    int n_evt;
    n_evt = 0;
    do_reset();
    bus.evt_ready = 1'b0;
    btn_db[1] = 1'b1;
    @(negedge clk); btn_db[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.evt_valid !== 1'b1 || bus.evt_id !== 2'd1) begin
      errors++; $display("FAIL ovf_first got valid=%b id=%0d exp valid=1 id=1", bus.evt_valid, bus.evt_id);
    end
    btn_db[1] = 1'b1;
    @(negedge clk); btn_db[1] = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_queued got=%b exp=0", ovf); end
    @(negedge clk); btn_db[1] = 1'b1;
    checks++;
    if (bus.evt_id !== 2'd1) begin errors++; $display("FAIL ovf_id_stable got=%0d exp=1", bus.evt_id); end
    @(negedge clk); btn_db[1] = 1'b0;
    checks++;
    if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", ovf); end
    checks++;
    if (bus.evt_valid !== 1'b1 || bus.evt_id !== 2'd1) begin
      errors++; $display("FAIL ovf_hold got valid=%b id=%0d exp valid=1 id=1", bus.evt_valid, bus.evt_id);
    end
    bus.evt_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (bus.evt_valid === 1'b1) begin
        n_evt++;
        $display("ovf: event id=%0d accepted", bus.evt_id);
      end
      @(negedge clk);
    end
    checks++;
    if (n_evt != 2) begin errors++; $display("FAIL ovf_count got=%0d exp=2", n_evt); end
    checks++;
    if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
    ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
  endtask

  task automatic test_ovf_clr_priority;
    do_reset();
    bus.evt_ready = 1'b0;
    btn_db[3] = 1'b1;
    @(negedge clk); btn_db[3] = 1'b0;
    @(negedge clk); btn_db[3] = 1'b1;
    @(negedge clk); btn_db[3] = 1'b0;
    @(negedge clk); btn_db[3] = 1'b1; ovf_clr = 1'b1;
    @(negedge clk); btn_db[3] = 1'b0; ovf_clr = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL clr_priority got=%b exp=0", ovf); end
    checks++;
    if (bus.evt_valid !== 1'b1 || bus.evt_id !== 2'd3) begin
      errors++; $display("FAIL clr_priority_evt got valid=%b id=%0d exp valid=1 id=3", bus.evt_valid, bus.evt_id);
    end
    $display("clr_priority: event id=%0d held", bus.evt_id);
  endtask

  task automatic test_grant_collision;
    int n_evt;
    n_evt = 0;
    do_reset();
    bus.evt_ready = 1'b0;
    btn_db[2] = 1'b1;
    @(negedge clk); btn_db[2] = 1'b0;
    @(negedge clk); btn_db[2] = 1'b1;
    @(negedge clk); btn_db[2] = 1'b0;
    @(negedge clk); btn_db[2] = 1'b1; bus.evt_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (bus.evt_valid === 1'b1) begin
        n_evt++;
        $display("collision: event id=%0d accepted", bus.evt_id);
        checks++;
        if (bus.evt_id !== 2'd2) begin errors++; $display("FAIL collision_id got=%0d exp=2", bus.evt_id); end
      end
      @(negedge clk);
    end
    btn_db[2] = 1'b0;
    checks++;
    if (n_evt != 3) begin errors++; $display("FAIL collision_count got=%0d exp=3", n_evt); end
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL collision_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_reset_mid;
    int n_evt;
    n_evt = 0;
    do_reset();
    bus.evt_ready = 1'b0;
    btn_db = 4'b1011;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.evt_valid !== 1'b1 || bus.evt_id !== 2'd0) begin
      errors++; $display("FAIL midrst_pre got valid=%b id=%0d exp valid=1 id=0", bus.evt_valid, bus.evt_id);
    end
    #2;
    rst_n = 1'b0;
    btn_db = 4'b0100;
    #1;
    checks++;
    if (bus.evt_valid !== 1'b0) begin errors++; $display("FAIL midrst_async got=%b exp=0", bus.evt_valid); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.evt_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.evt_valid === 1'b1) begin
        n_evt++;
        $display("midrst: event id=%0d after release", bus.evt_id);
        checks++;
        if (bus.evt_id !== 2'd2) begin errors++; $display("FAIL midrst_id got=%0d exp=2", bus.evt_id); end
      end
    end
    btn_db = '0;
    checks++;
    if (n_evt != 1) begin errors++; $display("FAIL midrst_count got=%0d exp=1", n_evt); end
  endtask

`ifdef BTN_AUTO_REPEAT_EN
  task automatic test_auto_repeat;
    int n_evt;
    logic exp_v;
    n_evt = 0;
    do_reset();
    bus.evt_ready = 1'b1;
    btn_db[1] = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      exp_v = (c == 2) || (c >= 12 && c <= 32 && ((c - 12) % 4) == 0);
      checks++;
      if (bus.evt_valid !== exp_v) begin errors++; $display("FAIL repeat_valid c=%0d got=%b exp=%b", c, bus.evt_valid, exp_v); end
      if (bus.evt_valid === 1'b1) begin
        n_evt++;
        $display("repeat: event id=%0d at cycle %0d", bus.evt_id, c);
        checks++;
        if (bus.evt_id !== 2'd1) begin errors++; $display("FAIL repeat_id got=%0d exp=1", bus.evt_id); end
      end
      if (c == 31) btn_db[1] = 1'b0;
    end
    checks++;
    if (n_evt != 7) begin errors++; $display("FAIL repeat_count got=%0d exp=7", n_evt); end
  endtask
`endif

  initial begin
    bus.evt_ready = 1'b0;
    test_reset();
    test_single_press();
    test_back_to_back();
    test_rr_wrap();
    test_overflow();
    test_ovf_clr_priority();
    test_grant_collision();
    test_reset_mid();
`ifdef BTN_AUTO_REPEAT_EN
    test_auto_repeat();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/btn_event_arbiter.md
Name: btn_event_arbiter

Overview:
- Collects debounced push-button levels from up to N_BTN buttons and converts each press into a single event.
- Queues one pending event per button and hands events one at a time to a downstream consumer (FSM, display or counter controller) over a valid/ready handshake.
- Shares the single consumer fairly between buttons with round-robin priority.
- Sits between the per-button debouncers and the application control logic.

Parameters:
- N_BTN, 4, number of button inputs (2..8).
- ID_W, 2, width of evt_id; must satisfy 2^ID_W >= N_BTN.
- REPEAT_DELAY, 50000000, clock cycles a button must be held before the first auto-repeat (AUTO_REPEAT_EN only).
- REPEAT_PERIOD, 10000000, clock cycles between subsequent auto-repeats (AUTO_REPEAT_EN only).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- btn_db  in  N_BTN  debounced button levels, synchronous to clk, 1 = pressed.
- evt_valid  out  1  an event is presented on evt_id.
- evt_id  out  ID_W  index of the button that produced the event.
- evt_ready  in  1  consumer accepts the event in any cycle where evt_valid && evt_ready.
- ovf  out  1  sticky flag: a press was dropped.
- ovf_clr  in  1  synchronous clear for ovf.

Behaviour:
- Reset values (rst_n low, asynchronous):
  - evt_valid=0, evt_id=0, ovf=0.
  - All pending bits 0; all per-button delay registers 0.
  - last_grant=N_BTN-1, so button 0 has first priority.
- Edge detection, per button i:
  - edge[i] = btn_db[i] & ~dly[i]; dly[i] <= btn_db[i] every cycle.
  - Exactly one edge per low-to-high transition; holding the button produces nothing further (without AUTO_REPEAT_EN).
- Pending:
  - edge[i] sets pending[i].
  - If pending[i] is already 1 and is not being granted in the same cycle, the edge is dropped and ovf <= 1.
  - A dropped press never produces an event.
- Output register load:
  - Loads when ~evt_valid, or when evt_valid && evt_ready (the slot frees the same cycle).
  - Selects the first set pending bit searching from last_grant+1 upward, wrapping modulo N_BTN.
  - On load: evt_valid <= 1, evt_id <= winner, last_grant <= winner, pending[winner] <= 0.
  - If nothing is pending, evt_valid <= 0 on accept, or stays 0.
- Simultaneous grant and new edge on the same button:
  - The pending clear loses; pending[i] remains 1 with the new press queued.
  - No overflow is flagged.
- Handshake rules:
  - evt_id is stable while evt_valid && ~evt_ready.
  - Back-to-back events are possible: one per cycle while evt_ready is held high.
- Latency:
  - btn_db rises before clock edge k, so edge is seen at k and pending is set at k.
  - evt_valid is high after edge k+1 when the output is idle: 2 cycles from input rise to valid.
- ovf:
  - ovf_clr has priority over a same-cycle new overflow: ovf reads 0 afterwards.
  - ovf stays set until it is cleared.
- Reset mid-operation: all pending events and any presented event are discarded immediately; no partial event follows reset release.
- A button held through reset release produces an edge on the first clock after release, because dly resets to 0.

Optional Feature:
- Macro: BTN_AUTO_REPEAT_EN.
- Defined:
  - Each button has a hold counter that clears when btn_db[i]=0.
  - When the hold count reaches REPEAT_DELAY, a synthetic edge is raised, then another every REPEAT_PERIOD cycles while the button stays held.
  - Synthetic edges are treated exactly like real edges, including the overflow rules.
  - Counter width is $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1); the counter never wraps.
- Undefined: no hold counters are synthesized and behaviour is as described above.

Test Plan:
- Reset, then single press of btn 2 held 20 cycles with evt_ready=1 -> exactly one event with evt_id=2; evt_valid high 2 cycles after the rise for 1 cycle; ovf=0.
- btn 0, 1 and 3 rise in the same cycle, evt_ready=1, after reset -> events 0, 1, 3 on 3 consecutive cycles.
- After last_grant=1, btn 0 and 3 pending -> grant order 3 then 0 (round-robin wrap).
- evt_ready=0, btn 1 pressed, released, pressed again, released, pressed a third time -> evt_id=1 held stable; second press queued, third dropped; ovf=1; raising evt_ready yields exactly 2 events; ovf_clr pulse -> ovf=0.
- rst_n asserted mid-cycle while evt_valid=1 and 2 events are pending -> evt_valid drops immediately; no events after release unless a button is held (held btn 2 -> one event with evt_id=2).
- BTN_AUTO_REPEAT_EN with REPEAT_DELAY=10, REPEAT_PERIOD=4, btn 1 held 30 cycles, evt_ready=1 -> initial event plus repeats at hold counts 10, 14, 18, 22, 26, 30 (7 events total); release stops repeats.
